// File: rtl/huffman_decoder.sv
// Serial decoder for a six-symbol prefix code, one stream bit per cycle, MSB (root side) first.
// Latency: sym_valid/err pulse the cycle after the edge that accepts a codeword's final bit.
// Backpressure: bit_ready is high only while a table is loaded; bits offered while it is low are dropped.
module huffman_decoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       code_valid,
   input  logic [7:0] HC1,
   input  logic [7:0] HC2,
   input  logic [7:0] HC3,
   input  logic [7:0] HC4,
   input  logic [7:0] HC5,
   input  logic [7:0] HC6,
   input  logic [7:0] M1,
   input  logic [7:0] M2,
   input  logic [7:0] M3,
   input  logic [7:0] M4,
   input  logic [7:0] M5,
   input  logic [7:0] M6,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic       bit_ready,
   output logic       sym_valid,
   output logic [2:0] sym_out,
   output logic       err,
   output logic [7:0] dec_cnt
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [5:0][7:0] hc_q, hc_d;
   logic [5:0][7:0] m_q, m_d;
   logic [7:0]      acc_q, acc_d;
   logic [3:0]      len_q, len_d;
   logic            bit_ready_q, bit_ready_d;
   logic            sym_valid_q, sym_valid_d;
   logic [2:0]      sym_out_q, sym_out_d;
   logic            err_q, err_d;
   logic [7:0]      dec_cnt_q, dec_cnt_d;

   logic [7:0]      nacc;
   logic [3:0]      nlen;
   logic [7:0]      len_mask;
   logic            hit;
   logic [2:0]      hit_idx;

   // Candidate codeword after the current bit and the lowest-index table match for it.
   always_comb begin
      nacc     = {acc_q[6:0], bit_in};
      nlen     = len_q + 4'd1;
      len_mask = 8'hFF >> (4'd8 - nlen);
      hit      = 1'b0;
      hit_idx  = 3'd0;
      // Walk from the top so the lowest matching index is the one that sticks.
      for (int i = 5; i >= 0; i--) begin
         if ((m_q[i] == len_mask) && (m_q[i] != 8'h00) &&
             ((nacc & m_q[i]) == (hc_q[i] & m_q[i]))) begin
            hit     = 1'b1;
            hit_idx = 3'(i + 1);
         end
      end
   end

   // Next-state, table capture and decode outcome.
   always_comb begin
      state_d     = state_q;
      hc_d        = hc_q;
      m_d         = m_q;
      acc_d       = acc_q;
      len_d       = len_q;
      sym_valid_d = 1'b0;
      sym_out_d   = sym_out_q;
      err_d       = 1'b0;
      dec_cnt_d   = dec_cnt_q;
      case (state_q)
         IDLE: begin
            if (code_valid) begin
               state_d = RUN;
               hc_d    = {HC6, HC5, HC4, HC3, HC2, HC1};
               m_d     = {M6, M5, M4, M3, M2, M1};
            end
         end
         RUN: begin
            if (!code_valid) begin
               // Table withdrawn: any bit offered this cycle is discarded with the partial codeword.
               state_d   = IDLE;
               acc_d     = 8'd0;
               len_d     = 4'd0;
               dec_cnt_d = 8'd0;
            end else if (bit_valid) begin
               if (hit) begin
                  sym_valid_d = 1'b1;
                  sym_out_d   = hit_idx;
                  dec_cnt_d   = dec_cnt_q + 8'd1;
                  acc_d       = 8'd0;
                  len_d       = 4'd0;
               end else if (nlen == 4'd8) begin
                  err_d = 1'b1;
                  acc_d = 8'd0;
                  len_d = 4'd0;
               end else begin
                  acc_d = nacc;
                  len_d = nlen;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      bit_ready_d = (state_d == RUN);
   end

   // State, table and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         hc_q        <= '0;
         m_q         <= '0;
         acc_q       <= 8'd0;
         len_q       <= 4'd0;
         bit_ready_q <= 1'b0;
         sym_valid_q <= 1'b0;
         sym_out_q   <= 3'd0;
         err_q       <= 1'b0;
         dec_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         hc_q        <= hc_d;
         m_q         <= m_d;
         acc_q       <= acc_d;
         len_q       <= len_d;
         bit_ready_q <= bit_ready_d;
         sym_valid_q <= sym_valid_d;
         sym_out_q   <= sym_out_d;
         err_q       <= err_d;
         dec_cnt_q   <= dec_cnt_d;
      end
   end

   assign bit_ready = bit_ready_q;
   assign sym_valid = sym_valid_q;
   assign sym_out   = sym_out_q;
   assign err       = err_q;
   assign dec_cnt   = dec_cnt_q;

endmodule
